// File: rtl/matrix_skew_feeder.sv
// matrix_skew_feeder: buffers an NxN matrix in row-major order, then streams it
// as 2N-1 skewed slices (lane j delayed by j cycles) into a systolic array edge.
module matrix_skew_feeder #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           out_en,
  output logic [N*W-1:0] x_out,
  output logic [N-1:0]   x_valid,
  output logic           frame_done
);
  localparam int TW = (N > 1) ? $clog2(2*N-1) : 1;
  localparam int IW = (N > 1) ? $clog2(N*N) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(2*N-2);
  localparam logic [IW-1:0] I_LAST = IW'(N*N-1);
  typedef enum logic {LOAD, STREAM} state_t;
  state_t         r_state, w_next;
  logic [IW-1:0]  r_idx;
  logic [TW-1:0]  r_t;
  logic [W-1:0]   r_mat [N*N];
  logic [N*W-1:0] w_slice;
  logic [N-1:0]   w_sv;
  logic           w_acc, w_adv, w_last;
  assign in_ready = r_state == LOAD;
  assign w_acc    = in_ready && in_valid;
  assign w_adv    = r_state == STREAM && out_en;
  assign w_last   = r_t == T_LAST;
  always_comb begin
    w_next = r_state;
    if (w_acc && r_idx == I_LAST) w_next = STREAM;
    else if (w_adv && w_last) w_next = LOAD;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= LOAD;
    else r_state <= w_next;
  // Storage is only written in LOAD, so streaming can never be corrupted.
  always_ff @(posedge clk)
    if (w_acc) r_mat[r_idx] <= in_data;
  // Lane j carries A[t-j][j] while that row index is inside the matrix.
  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [TW-1:0] w_r;
    logic [IW-1:0] w_a;
    assign w_r     = r_t - TW'(j);
    assign w_sv[j] = r_t >= TW'(j) && w_r < TW'(N);
    assign w_a     = IW'(w_r) * IW'(N) + IW'(j);
    assign w_slice[W*j +: W] = w_sv[j] ? r_mat[w_a] : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_idx      <= '0;
      r_t        <= '0;
      x_out      <= '0;
      x_valid    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_adv && w_last;
      if (w_acc) r_idx <= (r_idx == I_LAST) ? '0 : r_idx + IW'(1);
      if (r_state == LOAD) begin
        x_out   <= '0;
        x_valid <= '0;
        r_t     <= '0;
      end else if (out_en) begin
        x_out   <= w_slice;
        x_valid <= w_sv;
        r_t     <= w_last ? '0 : r_t + TW'(1);
      end
    end
endmodule

// File: tb/tb_matrix_skew_feeder.sv
// tb_matrix_skew_feeder: randomized self-checking bench; expected slices come
// from the diagonal rule lane j = A[t-j][j] applied to the bench's own matrix copy.
module tb_matrix_skew_feeder;
  localparam int N = 4;
  localparam int W = 32;
  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic           out_en;
  logic [N*W-1:0] x_out;
  logic [N-1:0]   x_valid;
  logic           frame_done;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] m [N*N];

  matrix_skew_feeder #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_en(out_en), .x_out(x_out), .x_valid(x_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] exp_slice(int t);
    logic [N*W-1:0] v = '0;
    for (int j = 0; j < N; j++) begin
      int r = t - j;
      if (r >= 0 && r < N) v[W*j +: W] = m[r*N + j];
    end
    return v;
  endfunction

  function automatic logic [N-1:0] exp_valid(int t);
    logic [N-1:0] v = '0;
    for (int j = 0; j < N; j++) v[j] = (t - j >= 0) && (t - j < N);
    return v;
  endfunction

  task automatic load_frame(input bit gaps);
    int i = 0;
    int c = 0;
    while (i < N*N) begin
      @(negedge clk);
      out_en = 1'($urandom_range(0, 1));
      if (gaps && c % 2 == 1) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_data  = m[i];
        i++;
      end
      c++;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready word=%0d in_ready=%b exp=1", i, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_en   = 1'b0;
    checks++;
    if (x_out !== '0 || x_valid !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_stream x_out=%h x_valid=%b in_ready=%b exp zero/0/0", x_out, x_valid, in_ready);
    end
  endtask

  task automatic stream_frame(input int stall_at, input int stall_len, input bit noise, input int stop_at);
    for (int t = 0; t < 2*N-1; t++) begin
      out_en = 1'b1;
      if (noise) begin
        in_valid = 1'b1;
        in_data  = $urandom;
      end
      @(posedge clk);
      #1;
      checks++;
      if (x_out !== exp_slice(t) || x_valid !== exp_valid(t) || frame_done !== (t == 2*N-2)) begin
        errors++;
        $display("FAIL slice t=%0d x_out=%h exp=%h x_valid=%b exp=%b frame_done=%b exp=%b",
                 t, x_out, exp_slice(t), x_valid, exp_valid(t), frame_done, t == 2*N-2);
      end
      if (t == stop_at) return;
      if (t == stall_at)
        for (int k = 0; k < stall_len; k++) begin
          out_en = 1'b0;
          @(posedge clk);
          #1;
          checks++;
          if (x_out !== exp_slice(t) || x_valid !== exp_valid(t) || frame_done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall t=%0d k=%0d x_out=%h exp=%h x_valid=%b exp=%b frame_done=%b",
                     t, k, x_out, exp_slice(t), x_valid, exp_valid(t), frame_done);
          end
        end
    end
    in_valid = 1'b0;
    out_en   = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_done in_ready=%b exp=1", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (x_out !== '0 || x_valid !== '0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL load_zero x_out=%h x_valid=%b frame_done=%b exp zero", x_out, x_valid, frame_done);
    end
  endtask

  task automatic rand_matrix();
    for (int i = 0; i < N*N; i++) m[i] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_en = 1'b0; in_data = '0;
    #1;
    checks++;
    if (x_out !== '0 || x_valid !== '0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset x_out=%h x_valid=%b frame_done=%b in_ready=%b", x_out, x_valid, frame_done, in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < N*N; i++) m[i] = W'(i + 1);
    load_frame(1'b0);
    stream_frame(-1, 0, 1'b0, -1);
  endtask

  task automatic test_gaps();
    for (int i = 0; i < N*N; i++) m[i] = W'(i + 1);
    load_frame(1'b1);
    stream_frame(-1, 0, 1'b0, -1);
  endtask

  task automatic test_stall();
    rand_matrix();
    load_frame(1'b0);
    stream_frame(2, 3, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    rand_matrix();
    load_frame(1'b0);
    stream_frame(-1, 0, 1'b0, 3);
    rst = 1'b0;
    #1;
    checks++;
    if (x_out !== '0 || x_valid !== '0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid x_out=%h x_valid=%b frame_done=%b in_ready=%b", x_out, x_valid, frame_done, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    rand_matrix();
    m[0] = 32'h40900000; m[1] = 32'hc0200000; m[2] = 32'h40000000; m[3] = 32'h41200000;
    load_frame(1'b0);
    stream_frame(-1, 0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    rand_matrix();
    load_frame(1'b0);
    stream_frame(-1, 0, 1'b0, -1);
    rand_matrix();
    load_frame(1'b1);
    stream_frame(-1, 0, 1'b0, -1);
  endtask

  task automatic test_stream_noise();
    rand_matrix();
    load_frame(1'b0);
    stream_frame(4, 2, 1'b1, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_stream_noise();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
